// File: rtl/aes_lane_array.sv
// Multi-lane AES-128 encryptor: NUM_LANES combinational cores share one key register.
// An IDLE/CALC/DONE controller captures a block set, registers the results and holds them until taken.

module aes_encrypt (
    input  logic [127:0] i_key,
    input  logic [127:0] i_pt,
    output logic [127:0] o_ct
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box from first principles: inverse as x^254 in GF(2^8), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = sbox(s[127-8*((i + 4*(i % 4)) % 16) -: 8]);
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return r;
    endfunction

    function automatic logic [127:0] next_round_key(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]) ^ rcon, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // NOTE: every local is assigned before it is read on every pass, so no latch is inferred.
    always_comb begin : aes_rounds
        logic [127:0] v_state;
        logic [127:0] v_key;
        logic [7:0]   v_rcon;
        v_key   = i_key;
        v_rcon  = 8'h01;
        v_state = i_pt ^ i_key;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            v_key   = next_round_key(v_key, v_rcon);
            v_rcon  = xtime(v_rcon);
            v_state = sub_shift(v_state);
            if (rnd != 10) v_state = mix_columns(v_state);
            v_state = v_state ^ v_key;
        end
        o_ct = v_state;
    end
endmodule

module aes_lane_array #(
    parameter int           NUM_LANES = 5,
    parameter logic [127:0] KEY_RESET = 128'h000102030405060708090a0b0c0d0e0f
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_valid,
    input  logic [127:0]             key_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_LANES-1:0]     lane_en,
    input  logic [NUM_LANES*128-1:0] in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_LANES*128-1:0] encrypted128,
    output logic [NUM_LANES-1:0]     out_lane_mask,
    output logic [15:0]              blk_count
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                   r_state;
    logic [127:0]             r_key;
    logic [NUM_LANES*128-1:0] r_in;
    logic [NUM_LANES*128-1:0] r_out;
    logic [NUM_LANES-1:0]     r_lane_en;
    logic [NUM_LANES-1:0]     r_mask;
    logic [15:0]              r_blk_count;
    logic [NUM_LANES*128-1:0] w_ct;
    logic                     w_accept;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        aes_encrypt u_core (
            .i_key (r_key),
            .i_pt  (r_in[128*g +: 128]),
            .o_ct  (w_ct[128*g +: 128])
        );
    end

    // A key offer always blocks input; DONE can accept only while its result is being taken.
    assign in_ready      = !rst && !key_valid && (r_state == IDLE || (r_state == DONE && out_ready));
    assign w_accept      = in_ready && in_valid;
    assign out_valid     = (r_state == DONE);
    assign encrypted128  = r_out;
    assign out_lane_mask = r_mask;
    assign blk_count     = r_blk_count;

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_key       <= KEY_RESET;
            r_in        <= '0;
            r_lane_en   <= '0;
            r_out       <= '0;
            r_mask      <= '0;
            r_blk_count <= 16'd0;
        end else begin
            case (r_state)
                IDLE: if (key_valid) r_key <= key_in;
                CALC: begin
                    for (int l = 0; l < NUM_LANES; l++)
                        r_out[128*l +: 128] <= r_lane_en[l] ? w_ct[128*l +: 128] : 128'd0;
                    r_mask  <= r_lane_en;
                    r_state <= DONE;
                end
                DONE: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            // Acceptance overrides the DONE->IDLE move, giving back-to-back operation.
            if (w_accept) begin
                r_in        <= in;
                r_lane_en   <= lane_en;
                r_blk_count <= r_blk_count + 16'd1;
                r_state     <= CALC;
            end
        end
    end
endmodule

// File: tb/tb_aes_lane_array.sv
// Randomized and directed bench for aes_lane_array, checked every cycle against a
// transaction-level reference model with its own table-driven AES.

module tb_aes_lane_array;
    localparam int NL = 5;
    localparam int W  = NL * 128;
    localparam logic [127:0] KEY0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          key_valid = 1'b0;
    logic [127:0]  key_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NL-1:0] lane_en = '0;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  encrypted128;
    logic [NL-1:0] out_lane_mask;
    logic [15:0]   blk_count;

    aes_lane_array #(.NUM_LANES(NL), .KEY_RESET(KEY0)) dut (
        .clk           (clk),
        .rst           (rst),
        .key_valid     (key_valid),
        .key_in        (key_in),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .lane_en       (lane_en),
        .in            (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .encrypted128  (encrypted128),
        .out_lane_mask (out_lane_mask),
        .blk_count     (blk_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference AES (table-driven, byte arrays) ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Walk the multiplicative group with generator 3 and its inverse in lockstep.
    task automatic build_sbox();
        logic [7:0] p, q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            sb[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] ref_aes(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   w [176];
        logic [7:0]   a [4];
        logic [7:0]   rc;
        logic [127:0] res;
        rc  = 8'h01;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            w[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ w[i];
        end
        for (int i = 16; i < 176; i += 4) begin
            for (int k = 0; k < 4; k++) a[k] = w[i-4+k];
            if (i % 16 == 0) begin
                a  = '{sb[w[i-3]] ^ rc, sb[w[i-2]], sb[w[i-1]], sb[w[i-4]]};
                rc = xt(rc);
            end
            for (int k = 0; k < 4; k++) w[i+k] = w[i-16+k] ^ a[k];
        end
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[(i + 4*(i % 4)) % 16]];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
                    s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
                end else begin
                    for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [W-1:0] ref_set(input logic [127:0] key, input logic [W-1:0] pts,
                                             input logic [NL-1:0] en);
        logic [W-1:0] r;
        r = '0;
        for (int l = 0; l < NL; l++)
            if (en[l]) r[128*l +: 128] = ref_aes(key, pts[128*l +: 128]);
        return r;
    endfunction

    // ---------------- transaction-level model ----------------
    logic [127:0]  m_key = KEY0;
    logic [15:0]   m_count = '0;
    bit            m_pending = 1'b0;
    bit            m_showing = 1'b0;
    logic [W-1:0]  m_pend_out = '0;
    logic [W-1:0]  m_out = '0;
    logic [NL-1:0] m_pend_mask = '0;
    logic [NL-1:0] m_mask = '0;
    bit            preload_en = 1'b0;
    bit            armed = 1'b0;

    // Input is taken only when nothing is in flight and any shown result is being consumed.
    function automatic bit exp_ready();
        return !rst && !key_valid && !m_pending && (!m_showing || out_ready);
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_key     = KEY0;
            m_count   = '0;
            m_pending = 1'b0;
            m_showing = 1'b0;
            m_out     = '0;
            m_mask    = '0;
        end else begin : model_step
            bit acc;
            bit idle;
            acc  = exp_ready() && in_valid;
            idle = !m_pending && !m_showing;
            if (m_pending) begin
                m_out     = m_pend_out;
                m_mask    = m_pend_mask;
                m_showing = 1'b1;
                m_pending = 1'b0;
            end else if (m_showing && out_ready) begin
                m_showing = 1'b0;
            end
            if (idle && key_valid) m_key = key_in;
            if (acc) begin
                m_pend_out  = ref_set(m_key, in_data, lane_en);
                m_pend_mask = lane_en;
                m_pending   = 1'b1;
                m_count     = m_count + 16'd1;
            end
            if (preload_en) m_count = 16'hFFFF;
        end
    end

    initial forever begin
        @(negedge clk);
        if (armed) begin
            check("out_valid", out_valid, m_showing);
            check("in_ready", in_ready, exp_ready());
            check("encrypted128", encrypted128, m_out);
            check("out_lane_mask", out_lane_mask, m_mask);
            if (!preload_en) check("blk_count", blk_count, m_count);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        build_sbox();
        check("model_sbox_00", sb[8'h00], 8'h63);
        check("model_sbox_53", sb[8'h53], 8'hed);
        check("model_fips_a", ref_aes(KEY0, PT_A), CT_A);
        check("model_fips_b", ref_aes(KEY_B, PT_B), CT_B);

        // Reset with a set offered: it must never be accepted.
        rst = 1'b1; in_valid = 1'b1; lane_en = '1; in_data = {NL{PT_A}};
        tick(); armed = 1'b1; tick();
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_blk_count", blk_count, 16'd0);
        check("reset_data", encrypted128, '0);
        check("reset_mask", out_lane_mask, '0);

        // All lanes, FIPS-197 vector under the reset key.
        in_valid = 1'b1; lane_en = '1; in_data = {NL{PT_A}};
        tick();
        lane_en = 5'b10101;
        tick();
        check("fips_all_valid", out_valid, 1'b1);
        check("fips_all_data", encrypted128, {NL{CT_A}});
        check("fips_all_count", blk_count, 16'd1);

        // Sparse lanes, accepted back-to-back from DONE.
        tick(); tick();
        check("sparse_data", encrypted128, {CT_A, 128'h0, CT_A, 128'h0, CT_A});
        check("sparse_mask", out_lane_mask, 5'b10101);
        check("sparse_count", blk_count, 16'd2);

        // Stall in DONE for ten cycles with a set waiting.
        out_ready = 1'b0; lane_en = '1;
        for (int l = 0; l < NL; l++) in_data[128*l +: 128] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_valid", out_valid, 1'b1);
            check("stall_data", encrypted128, {CT_A, 128'h0, CT_A, 128'h0, CT_A});
            check("stall_ready", in_ready, 1'b0);
            check("stall_count", blk_count, 16'd2);
        end
        out_ready = 1'b1;
        #1 check("release_ready", in_ready, 1'b1);
        tick();
        check("b2b_calc_valid", out_valid, 1'b0);
        check("b2b_count", blk_count, 16'd3);
        tick();
        check("b2b_done_valid", out_valid, 1'b1);

        // Key load in IDLE blocks input for that cycle.
        in_valid = 1'b0;
        tick();
        key_valid = 1'b1; key_in = KEY_B; in_valid = 1'b1; in_data = {NL{PT_B}};
        #1 check("keyload_ready", in_ready, 1'b0);
        tick();
        key_valid = 1'b0; key_in = '0;
        tick(); tick();
        check("fips_b_valid", out_valid, 1'b1);
        check("fips_b_data", encrypted128, {NL{CT_B}});

        // Reset while a set is in CALC: it must be discarded and the key restored.
        in_data = {NL{PT_A}};
        tick();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_calc_valid", out_valid, 1'b0);
            check("rst_calc_data", encrypted128, '0);
            check("rst_calc_count", blk_count, 16'd0);
            tick();
        end
        in_valid = 1'b1; lane_en = '1; in_data = {NL{PT_A}};
        tick();
        in_valid = 1'b0;
        tick();
        check("rst_key_data", encrypted128, {NL{CT_A}});
        check("rst_key_count", blk_count, 16'd1);

        // Randomized traffic.
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            key_valid = ($urandom_range(9) == 0);
            key_in    = {$urandom, $urandom, $urandom, $urandom};
            lane_en   = NL'($urandom);
            for (int l = 0; l < NL; l++) in_data[128*l +: 128] = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end

        // Counter wrap, using an all-lanes-off set.
        in_valid = 1'b0; key_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        force dut.r_blk_count = 16'hFFFF;
        preload_en = 1'b1;
        tick();
        release dut.r_blk_count;
        preload_en = 1'b0;
        #1 check("preload_count", blk_count, 16'hFFFF);
        in_valid = 1'b1; lane_en = '0;
        tick();
        check("wrap_count", blk_count, 16'd0);
        in_valid = 1'b0;
        tick();
        check("zero_lane_valid", out_valid, 1'b1);
        check("zero_lane_data", encrypted128, '0);
        check("zero_lane_mask", out_lane_mask, '0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
